// File: rtl/barrett_mm_seq.sv
// rtl/barrett_mm_seq.sv - digit-serial Barrett modular multiplier, Z = (X*Y) mod MOD
module barrett_mm_seq #(
    parameter int N     = 8,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [N-1:0]     X,
    input  logic [N-1:0]     Y,
    input  logic [N-1:0]     MOD,
    input  logic [DIGIT+4:0] MU,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [N-1:0]     Z
);
    localparam int K  = N / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    // ACC < 2*MOD keeps T below 3*MOD*2^DIGIT, so two guard bits above N+DIGIT suffice
    localparam int TW = N + DIGIT + 2;
    localparam int HW = TW - (N - 2);
    localparam int MW = DIGIT + 5;
    localparam int PW = HW + MW;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CORR = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    if ((N % DIGIT) != 0 || DIGIT < 2) begin : g_param_check
        $error("barrett_mm_seq: N must be a multiple of DIGIT and DIGIT >= 2");
    end

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  x_l;
    logic [N-1:0]  y_l;
    logic [N-1:0]  mod_l;
    logic [MW-1:0] mu_l;
    logic [N:0]    acc;
    logic [N-1:0]  z_r;
    logic          err_r;

    logic [DIGIT-1:0] yd;
    logic [TW-1:0]    t;
    logic [HW-1:0]    t_hi;
    logic [PW-1:0]    prod;
    logic [HW-1:0]    q;
    logic [TW-1:0]    qm;
    logic [N:0]       acc_next;
    logic [N-1:0]     z_sub;

    // One Barrett step: shift in the next multiplier digit, estimate the quotient, subtract
    always_comb begin
        yd       = y_l[N-1 -: DIGIT];
        t        = (TW'(acc) << DIGIT) + TW'(x_l) * TW'(yd);
        t_hi     = HW'(t >> (N - 2));
        prod     = PW'(t_hi) * PW'(mu_l);
        q        = HW'(prod >> MW);
        qm       = TW'(q) * TW'(mod_l);
        acc_next = (N+1)'(t - qm);
        z_sub    = N'(acc - {1'b0, mod_l});
    end

    // Control FSM plus operand latches, accumulator and result registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            x_l   <= '0;
            y_l   <= '0;
            mod_l <= '0;
            mu_l  <= '0;
            acc   <= '0;
            z_r   <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (MOD[N-1]) begin
                            x_l   <= X;
                            y_l   <= Y;
                            mod_l <= MOD;
                            mu_l  <= MU;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= S_RUN;
                        end else begin
                            // Unnormalised modulus: report straight away, no arithmetic
                            err_r <= 1'b1;
                            z_r   <= '0;
                            state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    y_l <= y_l << DIGIT;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_CORR;
                    end
                end
                S_CORR: begin
                    z_r   <= (acc >= {1'b0, mod_l}) ? z_sub : acc[N-1:0];
                    err_r <= 1'b0;
                    state <= S_FIN;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state != S_IDLE);
    // Gated by reset so a reset landing in the FIN cycle suppresses the pulse
    assign DONE = (state == S_FIN) && RST;
    assign ERR  = err_r;
    assign Z    = z_r;

endmodule

// File: tb/tb_barrett_mm_seq.sv
// tb/tb_barrett_mm_seq.sv - self-checking bench for barrett_mm_seq
module tb_barrett_mm_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic st8, st16, st32;
    logic [7:0]  x8, y8, m8, z8;
    logic [8:0]  mu8;
    logic [15:0] x16, y16, m16, z16;
    logic [8:0]  mu16;
    logic [31:0] x32, y32, m32, z32;
    logic [12:0] mu32;
    logic busy8, done8, err8;
    logic busy16, done16, err16;
    logic busy32, done32, err32;

    int checks = 0;
    int errors = 0;
    logic inv_en = 1'b0;
    longint unsigned cur_m16 = 0;
    longint unsigned cur_m32 = 0;

    barrett_mm_seq #(.N(8), .DIGIT(4)) u8 (
        .CLK(clk), .RST(rst), .START(st8), .X(x8), .Y(y8), .MOD(m8), .MU(mu8),
        .BUSY(busy8), .DONE(done8), .ERR(err8), .Z(z8)
    );
    barrett_mm_seq #(.N(16), .DIGIT(4)) u16 (
        .CLK(clk), .RST(rst), .START(st16), .X(x16), .Y(y16), .MOD(m16), .MU(mu16),
        .BUSY(busy16), .DONE(done16), .ERR(err16), .Z(z16)
    );
    barrett_mm_seq #(.N(32), .DIGIT(8)) u32 (
        .CLK(clk), .RST(rst), .START(st32), .X(x32), .Y(y32), .MOD(m32), .MU(mu32),
        .BUSY(busy32), .DONE(done32), .ERR(err32), .Z(z32)
    );

    typedef struct {
        longint unsigned x, y, m, mu, z;
        logic            err;
    } vec_t;

    function automatic longint unsigned ref_mm(longint unsigned x, longint unsigned y, longint unsigned m);
        return (x * y) % m;
    endfunction

    function automatic longint unsigned mu_of(int n, int d, longint unsigned m);
        longint unsigned one = 1;
        return (one << (n + d + 3)) / m;
    endfunction

    function automatic logic busy_of(int sel);
        case (sel)
            0:       return busy8;
            1:       return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic logic done_of(int sel);
        case (sel)
            0:       return done8;
            1:       return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic err_of(int sel);
        case (sel)
            0:       return err8;
            1:       return err16;
            default: return err32;
        endcase
    endfunction

    function automatic longint unsigned z_of(int sel);
        case (sel)
            0:       return {56'd0, z8};
            1:       return {48'd0, z16};
            default: return {32'd0, z32};
        endcase
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input longint unsigned x, input longint unsigned y,
                         input longint unsigned m, input longint unsigned mu);
        case (sel)
            0: begin st8 = s; x8 = 8'(x); y8 = 8'(y); m8 = 8'(m); mu8 = 9'(mu); end
            1: begin st16 = s; x16 = 16'(x); y16 = 16'(y); m16 = 16'(m); mu16 = 9'(mu); end
            default: begin st32 = s; x32 = 32'(x); y32 = 32'(y); m32 = 32'(m); mu32 = 13'(mu); end
        endcase
    endtask

    task automatic wait_idle(input int sel);
        int guard = 0;
        @(negedge clk);
        while (busy_of(sel) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("idle_timeout", 1, 0);
    endtask

    // Issue one request, scramble the inputs after acceptance, wait (bounded) for DONE
    task automatic run_op(input int sel, input longint unsigned x, input longint unsigned y,
                          input longint unsigned m, input longint unsigned mu,
                          output longint unsigned z, output logic err, output int lat);
        wait_idle(sel);
        drive(sel, 1'b1, x, y, m, mu);
        @(negedge clk);
        drive(sel, 1'b0, $urandom, $urandom, $urandom, $urandom);
        lat = 1;
        while (!done_of(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        z   = z_of(sel);
        err = err_of(sel);
    endtask

    // Accumulator bound monitor for the wide instances during random regression
    always @(negedge clk) begin
        if (inv_en && rst) begin
            if (busy16) begin
                checks++;
                if (!(64'(u16.acc) < 2 * cur_m16)) begin
                    errors++;
                    $display("FAIL acc16_bound: acc %0d, limit %0d", u16.acc, 2 * cur_m16);
                end
            end
            if (busy32) begin
                checks++;
                if (!(64'(u32.acc) < 2 * cur_m32)) begin
                    errors++;
                    $display("FAIL acc32_bound: acc %0d, limit %0d", u32.acc, 2 * cur_m32);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        longint unsigned z, x, y, m, r;
        logic err;
        int lat, nb, nd, prev;

        vecs[0] = '{200, 150, 251, 130, 131, 1'b0};
        vecs[1] = '{250, 250, 251, 130, 1,   1'b0};
        vecs[2] = '{0,   77,  251, 130, 0,   1'b0};
        vecs[3] = '{1,   250, 251, 130, 250, 1'b0};
        vecs[4] = '{100, 100, 251, 130, 211, 1'b0};
        vecs[5] = '{254, 254, 255, 128, 1,   1'b0};
        vecs[6] = '{127, 127, 128, 256, 1,   1'b0};
        vecs[7] = '{100, 0,   100, 0,   0,   1'b1};
        vecs[8] = '{3,   5,   251, 130, 15,  1'b0};

        rst = 1'b0;
        drive(0, 1'b0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0);
        drive(2, 1'b0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        check("rst_busy8", busy8, 0);   check("rst_done8", done8, 0);
        check("rst_err8", err8, 0);     check("rst_z8", z8, 0);
        check("rst_busy16", busy16, 0); check("rst_z16", z16, 0);
        check("rst_busy32", busy32, 0); check("rst_z32", z32, 0);

        // START while reset is held must not launch anything
        drive(0, 1'b1, 200, 150, 251, 130);
        @(negedge clk);
        check("start_in_reset_busy", busy8, 0);
        drive(0, 1'b0, 200, 150, 251, 130);
        rst = 1'b1;
        @(negedge clk);
        check("start_in_reset_after", busy8, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(0, vecs[i].x, vecs[i].y, vecs[i].m, vecs[i].mu, z, err, lat);
            check($sformatf("vec%0d_z", i), z, vecs[i].z);
            check($sformatf("vec%0d_err", i), err, vecs[i].err);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].err ? 1 : 4);
        end

        // BUSY span and single DONE for a plain request
        wait_idle(0);
        drive(0, 1'b1, 200, 150, 251, 130);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0, 0);
        nb = 0; nd = 0;
        repeat (8) begin
            if (busy8) nb++;
            if (done8) nd++;
            @(negedge clk);
        end
        check("busy_span", nb, 4);
        check("busy_span_dones", nd, 1);
        check("busy_span_z", z8, 131);

        // START pulsed mid-operation is ignored
        wait_idle(0);
        drive(0, 1'b1, 200, 150, 251, 130);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0, 0);
        nd = 0;
        for (int i = 1; i <= 10; i++) begin
            if (done8) nd++;
            if (i == 2) drive(0, 1'b1, 7, 9, 251, 130);
            else if (i == 3) drive(0, 1'b0, 7, 9, 251, 130);
            @(negedge clk);
        end
        check("busy_start_dones", nd, 1);
        check("busy_start_z", z8, 131);
        check("busy_start_no_queue", busy8, 0);

        // Reset in the second RUN cycle aborts without DONE
        wait_idle(0);
        drive(0, 1'b1, 200, 150, 251, 130);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", busy8, 0);
        check("abort_z", z8, 0);
        check("abort_err", err8, 0);
        nd = 0;
        repeat (8) begin
            if (done8) nd++;
            @(negedge clk);
        end
        check("abort_dones", nd, 0);
        run_op(0, 250, 250, 251, 130, z, err, lat);
        check("after_abort_z", z, 1);
        check("after_abort_lat", lat, 4);

        // Reset landing in the FIN cycle suppresses DONE
        wait_idle(0);
        drive(0, 1'b1, 1, 250, 251, 130);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("fin_reset_done", done8, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("fin_reset_busy", busy8, 0);
        check("fin_reset_z", z8, 0);
        nd = 0;
        repeat (4) begin
            if (done8) nd++;
            @(negedge clk);
        end
        check("fin_reset_dones", nd, 0);

        // START held high: one result every N/DIGIT+3 cycles
        wait_idle(0);
        drive(0, 1'b1, 123, 45, 251, 130);
        nd = 0; prev = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (done8) begin
                if (nd > 0) check("b2b_interval", i - prev, 5);
                check("b2b_z", z8, ref_mm(123, 45, 251));
                prev = i;
                nd++;
            end
        end
        drive(0, 1'b0, 0, 0, 0, 0);
        check("b2b_dones", nd, 5);

        // Random regression on the wide instances against the arithmetic model
        inv_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m = longint'($urandom_range(32'hFFFF, 32'h8000));
            r = longint'($urandom); x = r % m;
            r = longint'($urandom); y = r % m;
            wait_idle(1);
            cur_m16 = m;
            run_op(1, x, y, m, mu_of(16, 4, m), z, err, lat);
            check("rnd16_z", z, ref_mm(x, y, m));
            check("rnd16_err", err, 0);
            check("rnd16_lat", lat, 6);
        end
        for (int i = 0; i < 30; i++) begin
            r = longint'($urandom);
            m = 64'h8000_0000 | (r & 64'h7FFF_FFFF);
            r = longint'($urandom); x = r % m;
            r = longint'($urandom); y = r % m;
            wait_idle(2);
            cur_m32 = m;
            run_op(2, x, y, m, mu_of(32, 8, m), z, err, lat);
            check("rnd32_z", z, ref_mm(x, y, m));
            check("rnd32_err", err, 0);
            check("rnd32_lat", lat, 6);
        end
        wait_idle(1);
        wait_idle(2);
        inv_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
